// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - segment map, funct3 codes and state encoding for the load/store unit
package load_store_unit_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam int          SEG_WORDS = 512;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_DATA,
    ST_WR,
    RMW_RD,
    RMW_DATA,
    RMW_WR
  } lsu_state_t;

  // Unsigned wrap makes anything below base fall far outside the window.
  function automatic logic in_segment(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          words);
    logic [31:0] off;
    off = addr - base;
    return off < 32'(4 * words);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half extract for loads and lane merge for sub-word stores
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_value,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_value = {24'd0, byte_sel};
      F3_HU:   load_value = {16'd0, half_sel};
      default: load_value = rdata;
    endcase
  end

  // Only the addressed lane changes; the rest of the word is passed through untouched.
  always_comb begin
    merge_word = rdata;
    case (funct3[1:0])
      2'b00: begin
        case (offset)
          2'd0:    merge_word[7:0]   = wdata[7:0];
          2'd1:    merge_word[15:8]  = wdata[7:0];
          2'd2:    merge_word[23:16] = wdata[7:0];
          default: merge_word[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (offset[1]) merge_word[31:16] = wdata[15:0];
        else           merge_word[15:0]  = wdata[15:0];
      end
      default: merge_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with sub-word read-modify-write
module load_store_unit #(
  parameter logic [31:0] TEXT_BASE = load_store_unit_pkg::TEXT_BASE,
  parameter logic [31:0] DATA_BASE = load_store_unit_pkg::DATA_BASE,
  parameter int          SEG_WORDS = load_store_unit_pkg::SEG_WORDS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);
  import load_store_unit_pkg::*;

  lsu_state_t  state, state_d;
  logic [1:0]  lat_offset, lat_offset_d;
  logic [2:0]  lat_funct3, lat_funct3_d;
  logic [31:0] lat_wdata, lat_wdata_d;

  logic [31:0] mem_address_d, mem_wdata_d, resp_rdata_d;
  logic        mem_write_d, mem_read_d, resp_valid_d, resp_error_d;

  logic        funct3_ok, align_ok, range_ok, req_legal;
  logic [31:0] load_value, merge_word;

  assign req_ready = (state == IDLE);

  always_comb begin
    if (req_write)
      funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                  (req_funct3 == F3_BU) || (req_funct3 == F3_HU);

    case (req_funct3[1:0])
      2'b01:   align_ok = !req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    range_ok  = in_segment(req_addr, TEXT_BASE, SEG_WORDS) ||
                in_segment(req_addr, DATA_BASE, SEG_WORDS);
    req_legal = funct3_ok && align_ok && range_ok;
  end

  lsu_lane_align u_lane_align (
    .rdata      (mem_rdata),
    .wdata      (lat_wdata),
    .offset     (lat_offset),
    .funct3     (lat_funct3),
    .load_value (load_value),
    .merge_word (merge_word)
  );

  always_comb begin
    state_d       = state;
    lat_offset_d  = lat_offset;
    lat_funct3_d  = lat_funct3;
    lat_wdata_d   = lat_wdata;
    mem_address_d = mem_address;
    mem_wdata_d   = mem_wdata;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    resp_valid_d  = 1'b0;
    resp_error_d  = 1'b0;
    resp_rdata_d  = 32'd0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_legal) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            lat_offset_d  = req_addr[1:0];
            lat_funct3_d  = req_funct3;
            lat_wdata_d   = req_wdata;
            mem_address_d = {req_addr[31:2], 2'b00};
            if (req_write && req_funct3 == F3_W) begin
              state_d     = ST_WR;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end else if (req_write) begin
              state_d    = RMW_RD;
              mem_read_d = 1'b1;
            end else begin
              state_d    = LD_RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      LD_RD:   state_d = LD_DATA;
      LD_DATA: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_value;
      end
      ST_WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      RMW_RD:  state_d = RMW_DATA;
      RMW_DATA: begin
        state_d     = RMW_WR;
        mem_wdata_d = merge_word;
        mem_write_d = 1'b1;
      end
      RMW_WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_offset  <= 2'd0;
      lat_funct3  <= 3'd0;
      lat_wdata   <= 32'd0;
      mem_address <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_error  <= 1'b0;
      resp_rdata  <= 32'd0;
    end else begin
      state       <= state_d;
      lat_offset  <= lat_offset_d;
      lat_funct3  <= lat_funct3_d;
      lat_wdata   <= lat_wdata_d;
      mem_address <= mem_address_d;
      mem_wdata   <= mem_wdata_d;
      mem_write   <= mem_write_d;
      mem_read    <= mem_read_d;
      resp_valid  <= resp_valid_d;
      resp_error  <= resp_error_d;
      resp_rdata  <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem [0:15] = '{default: 32'h0};
  int          rd_count = 0, wr_count = 0, overlap_count = 0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_error  (resp_error),
    .resp_rdata  (resp_rdata),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata)
  );

  // Word memory with registered read; all test addresses alias into 16 words.
  always @(posedge clock) begin
    if (mem_read) begin
      rd_count  <= rd_count + 1;
      mem_rdata <= mem[mem_address[5:2]];
    end
    if (mem_write) begin
      wr_count                <= wr_count + 1;
      mem[mem_address[5:2]]   <= mem_wdata;
      last_wr_addr            <= mem_address;
      last_wr_data            <= mem_wdata;
    end
    if (mem_read && mem_write) overlap_count <= overlap_count + 1;
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic err,
                        output logic [31:0] rd, output int nrd, output int nwr);
    int rd0, wr0;
    @(negedge clock);
    rd0 = rd_count;
    wr0 = wr_count;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    req_valid = 1'b0; req_write = ~w; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    while (!resp_valid && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    err = resp_error;
    rd  = resp_rdata;
    nrd = rd_count - rd0;
    nwr = wr_count - wr0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #2;
    compared++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: ready=%b rv=%b rd=%b wr=%b want 1 0 0 0", req_ready, resp_valid, mem_read, mem_write);
    end
    compared++;
    if (mem_address !== 32'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_address, mem_wdata, resp_rdata);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    compared++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: ready=%b rv=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_store_word();
    int lat, nrd, nwr; logic err; logic [31:0] rd;
    do_req(1'b1, 3'd2, 32'h1001_0004, 32'hDEAD_BEEF, lat, err, rd, nrd, nwr);
    compared++;
    if (lat !== 2 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL sw_resp: lat=%0d err=%b want 2 0", lat, err);
    end
    compared++;
    if (nwr !== 1 || nrd !== 0 || last_wr_addr !== 32'h1001_0004 || last_wr_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL sw_mem: wr=%0d rd=%0d addr=%h data=%h want 1 0 10010004 deadbeef", nwr, nrd, last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs [4] = '{32'h1001_0007, 32'h1001_0007, 32'h1001_0004, 32'h1001_0006};
    logic [31:0] exps [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'h0000_DEAD};
    int lat, nrd, nwr; logic err; logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, lat, err, rd, nrd, nwr);
      compared++;
      if (rd !== exps[i] || lat !== 3 || err !== 1'b0 || nrd !== 1 || nwr !== 0) begin
        mismatched++;
        $display("FAIL load_%0d: rdata=%h lat=%0d err=%b rd=%0d wr=%0d want %h 3 0 1 0", i, rd, lat, err, nrd, nwr, exps[i]);
      end
    end
  endtask

  task automatic test_rmw();
    int lat, nrd, nwr; logic err; logic [31:0] rd;
    do_req(1'b1, 3'd0, 32'h1001_0005, 32'hFFFF_FF11, lat, err, rd, nrd, nwr);
    compared++;
    if (lat !== 4 || err !== 1'b0 || nrd !== 1 || nwr !== 1 || last_wr_data !== 32'hDEAD_11EF) begin
      mismatched++;
      $display("FAIL sb_rmw: lat=%0d err=%b rd=%0d wr=%0d data=%h want 4 0 1 1 dead11ef", lat, err, nrd, nwr, last_wr_data);
    end
    do_req(1'b1, 3'd1, 32'h1001_0006, 32'hABCD_1234, lat, err, rd, nrd, nwr);
    compared++;
    if (lat !== 4 || err !== 1'b0 || nrd !== 1 || nwr !== 1 || last_wr_data !== 32'h1234_11EF) begin
      mismatched++;
      $display("FAIL sh_rmw: lat=%0d err=%b rd=%0d wr=%0d data=%h want 4 0 1 1 123411ef", lat, err, nrd, nwr, last_wr_data);
    end
    compared++;
    if (last_wr_addr !== 32'h1001_0004 || rd !== 32'h0) begin
      mismatched++;
      $display("FAIL sh_addr: addr=%h rdata=%h want 10010004 0", last_wr_addr, rd);
    end
  endtask

  task automatic test_errors();
    logic        ws   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [6] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4, 3'd2};
    logic [31:0] adrs [6] = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0000,
                              32'h2000_0000, 32'h1001_0000, 32'h1001_0800};
    int lat, nrd, nwr; logic err; logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      do_req(ws[i], f3s[i], adrs[i], 32'h7777_7777, lat, err, rd, nrd, nwr);
      compared++;
      if (err !== 1'b1 || lat !== 1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
        mismatched++;
        $display("FAIL error_%0d: err=%b lat=%0d rdata=%h rd=%0d wr=%0d want 1 1 0 0 0", i, err, lat, rd, nrd, nwr);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] adrs [3] = '{32'h0040_0000, 32'h0040_07FC, 32'h1001_07FC};
    int lat, nrd, nwr; logic err; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 3'd2, adrs[i], 32'h0, lat, err, rd, nrd, nwr);
      compared++;
      if (err !== 1'b0 || lat !== 3 || nrd !== 1) begin
        mismatched++;
        $display("FAIL bound_%0d: err=%b lat=%0d rd=%0d want 0 3 1", i, err, lat, nrd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h1001_0008; req_wdata = 32'hCAFE_F00D;
    @(posedge clock);
    cyc = 1;
    @(negedge clock);
    req_write = 1'b0; req_wdata = 32'h0;
    while (!resp_valid && cyc < 12) begin
      @(negedge clock);
      cyc++;
    end
    compared++;
    if (cyc !== 2 || req_ready !== 1'b1 || resp_error !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_sw: lat=%0d ready=%b err=%b want 2 1 0", cyc, req_ready, resp_error);
    end
    @(posedge clock);
    cyc = 1;
    @(negedge clock);
    req_valid = 1'b0;
    compared++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_accept: rv=%b ready=%b want 0 0", resp_valid, req_ready);
    end
    while (!resp_valid && cyc < 12) begin
      @(negedge clock);
      cyc++;
    end
    compared++;
    if (cyc !== 3 || resp_rdata !== 32'hCAFE_F00D || resp_error !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_lw: lat=%0d rdata=%h err=%b want 3 cafef00d 0", cyc, resp_rdata, resp_error);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int lat, nrd, nwr, wr0; logic err; logic [31:0] rd;
    do_req(1'b1, 3'd2, 32'h1001_000C, 32'hA5A5_A5A5, lat, err, rd, nrd, nwr);
    @(negedge clock);
    wr0 = wr_count;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h1001_000D; req_wdata = 32'h0000_003C;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0 ||
        mem_address !== 32'd0 || mem_wdata !== 32'd0 || resp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_rmw_out: ready=%b wr=%b rd=%b addr=%h wdata=%h rv=%b want 1 0 0 0 0 0",
               req_ready, mem_write, mem_read, mem_address, mem_wdata, resp_valid);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    compared++;
    if (wr_count !== wr0 || mem[3] !== 32'hA5A5_A5A5 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_rmw_mem: writes=%0d word=%h ready=%b rv=%b want %0d a5a5a5a5 1 0",
               wr_count - wr0, mem[3], req_ready, resp_valid, 0);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_extend();
    test_rmw();
    test_errors();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_rmw();
    compared++;
    if (overlap_count !== 0) begin
      mismatched++;
      $display("FAIL strobe_overlap: count=%0d want 0", overlap_count);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the execute stage and drives the word-addressed, single-port data memory.
- Memory has a 1-cycle registered read and no byte enables, so the unit:
  - extracts and extends byte/half loads;
  - performs read-modify-write (RMW) for SB/SH.
- Rejects misaligned, illegal or out-of-range accesses with an error response; no memory access is made for them.

Parameters:
- TEXT_BASE  32'h0040_0000  byte base of text segment; must equal the global TEXT constant.
- DATA_BASE  32'h1001_0000  byte base of data segment; must equal the global DATA constant.
- SEG_WORDS  512  words decoded per segment; the legal range is [base, base + 4*SEG_WORDS).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  combinational, equals (state == IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_error  out  1  valid with resp_valid; 1 = rejected access.
- resp_rdata  out  32  load result; 0 for stores and errors.
- mem_address  out  32  registered; req_addr with bits [1:0] forced to 0.
- mem_wdata  out  32  registered write word.
- mem_write  out  1  registered write strobe.
- mem_read  out  1  registered read strobe.
- mem_rdata  in  32  memory read data; valid the cycle after mem_read was sampled.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; latched request cleared;
  - all registered outputs = 0; req_ready = 1.
  - Reset mid-RMW aborts with no write. Reset while in ST_WR or RMW_WR drops mem_write immediately.
- Acceptance: on the edge where req_valid && req_ready. Address, funct3 and wdata are latched at that edge; the inputs are then don't-care.
- Legal funct3:
  - loads: 0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU;
  - stores: 0 = SB, 1 = SH, 2 = SW.
- Error cases (no memory strobe; next cycle resp_valid = 1, resp_error = 1, state stays IDLE):
  - illegal funct3 value;
  - H with addr[0] = 1;
  - W with addr[1:0] != 0;
  - address outside both segments.
- States: IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_DATA, RMW_WR.
  - IDLE -> LD_RD: legal load accepted; mem_read = 1.
  - IDLE -> ST_WR: legal SW accepted; mem_write = 1, mem_wdata = wdata.
  - IDLE -> RMW_RD: legal SB/SH accepted; mem_read = 1.
  - LD_RD -> LD_DATA: mem_read = 0.
  - LD_DATA -> IDLE: resp_rdata = extracted/extended mem_rdata; resp_valid = 1.
  - ST_WR -> IDLE: mem_write = 0; resp_valid = 1.
  - RMW_RD -> RMW_DATA: mem_read = 0.
  - RMW_DATA -> RMW_WR: mem_wdata = merged word; mem_write = 1.
  - RMW_WR -> IDLE: mem_write = 0; resp_valid = 1.
- Latency (edges after acceptance until resp_valid is high):
  - load: 3; SW: 2; SB/SH: 4; error: 1.
- resp_valid high exactly one cycle. req_ready may be 1 in the same cycle, so back-to-back requests are allowed. No overlap of strobes: mem_read && mem_write never both 1.
- Extract:
  - byte lane = addr[1:0]*8; half lane = addr[1]*16;
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Merge: replace only the addressed byte/half of mem_rdata with wdata[7:0]/[15:0]; other lanes are preserved bit-exact.

Decomposition:
- Shared package (params): TEXT/DATA bases, SEG_WORDS, funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), lsu state encoding.
- One sub-module, lsu_lane_align: purely combinational extract (rdata, offset, funct3 -> load value) and merge (rdata, wdata, offset, funct3 -> word). Reused for both paths.

Test Plan:
- Reset, then SW addr 0x1001_0004 data 0xDEADBEEF -> mem_write = 1, mem_address 0x1001_0004, mem_wdata 0xDEADBEEF; resp_valid 2 edges after acceptance; error = 0.
- After the above: LB 0x1001_0007 -> resp_rdata 0xFFFF_FFDE; LBU same address -> 0x0000_00DE; LH 0x1001_0004 -> 0xFFFF_BEEF; LHU 0x1001_0006 -> 0x0000_DEAD; each resp 3 edges after acceptance.
- SB 0x1001_0005 data 0x11 over 0xDEADBEEF -> one read then write of 0xDEAD11EF; SH 0x1001_0006 data 0x1234 -> 0x123411EF; resp 4 edges after acceptance.
- LW 0x1001_0002, SH 0x1001_0001, funct3 = 3, addr 0x2000_0000 -> resp_error = 1 next cycle, no mem_read/mem_write pulse, resp_rdata = 0.
- Back-to-back: SW then LW with req_valid held high -> second accepted in the cycle its predecessor's resp_valid is high; LW returns the stored word.
- Assert reset_n = 0 during RMW_DATA of an SB -> mem_write never pulses, memory word unchanged, outputs 0, req_ready = 1 after release.
